// File: rtl/span_walker_if.sv
// Bus between the VGA timing/config side and the span walker.
// The master drives timing and configuration; the slave returns per-pixel coverage.
interface span_walker_if;
  logic        line_end;
  logic [9:0]  line_y;
  logic [9:0]  pix_x;
  logic        cfg_we;
  logic [2:0]  cfg_slot;
  logic [2:0]  cfg_field;
  logic [13:0] cfg_data;
  logic        hit;
  logic [2:0]  hit_slot;
  logic        frame_commit;

  modport master (
    output line_end, line_y, pix_x, cfg_we, cfg_slot, cfg_field, cfg_data,
    input  hit, hit_slot, frame_commit
  );

  modport slave (
    input  line_end, line_y, pix_x, cfg_we, cfg_slot, cfg_field, cfg_data,
    output hit, hit_slot, frame_commit
  );
endinterface

// File: rtl/span_walker.sv
// Per-scanline trapezoid edge walker: shadow/active slot registers, per-line
// 10.4 edge accumulators and a registered highest-slot-wins coverage test.
module span_walker #(
  parameter int N_SLOTS = 4,
  parameter int V_TOTAL = 500
) (
  input logic         vga_clk,
  input logic         reset,
  span_walker_if.slave bus
);
  localparam logic [9:0] LAST_LINE = 10'(V_TOTAL - 1);

  logic [9:0]  ys_sh_r  [0:N_SLOTS-1];
  logic [9:0]  ye_sh_r  [0:N_SLOTS-1];
  logic [13:0] x0i_sh_r [0:N_SLOTS-1];
  logic [13:0] x1i_sh_r [0:N_SLOTS-1];
  logic [13:0] dx0_sh_r [0:N_SLOTS-1];
  logic [13:0] dx1_sh_r [0:N_SLOTS-1];
  logic        en_sh_r  [0:N_SLOTS-1];

  logic [9:0]  ys_r  [0:N_SLOTS-1];
  logic [9:0]  ye_r  [0:N_SLOTS-1];
  logic [13:0] x0i_r [0:N_SLOTS-1];
  logic [13:0] x1i_r [0:N_SLOTS-1];
  logic [13:0] dx0_r [0:N_SLOTS-1];
  logic [13:0] dx1_r [0:N_SLOTS-1];
  logic        en_r  [0:N_SLOTS-1];

  logic [13:0] x0_r    [0:N_SLOTS-1];
  logic [13:0] x1_r    [0:N_SLOTS-1];
  logic [13:0] x0_nx_s [0:N_SLOTS-1];
  logic [13:0] x1_nx_s [0:N_SLOTS-1];

  logic       commit_s;
  logic       hit_s;
  logic [2:0] slot_s;
  logic       hit_r;
  logic [2:0] hit_slot_r;
  logic       frame_commit_r;

  assign commit_s = bus.line_end && (bus.line_y == LAST_LINE);

  // Shadow field writes; out-of-range slot indices match no slot.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        ys_sh_r[s]  <= 10'd0;
        ye_sh_r[s]  <= 10'd0;
        x0i_sh_r[s] <= 14'd0;
        x1i_sh_r[s] <= 14'd0;
        dx0_sh_r[s] <= 14'd0;
        dx1_sh_r[s] <= 14'd0;
        en_sh_r[s]  <= 1'b0;
      end
    end else if (bus.cfg_we) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        if (bus.cfg_slot == 3'(s)) begin
          case (bus.cfg_field)
            3'd0:    ys_sh_r[s]  <= bus.cfg_data[9:0];
            3'd1:    ye_sh_r[s]  <= bus.cfg_data[9:0];
            3'd2:    x0i_sh_r[s] <= bus.cfg_data;
            3'd3:    x1i_sh_r[s] <= bus.cfg_data;
            3'd4:    dx0_sh_r[s] <= bus.cfg_data;
            3'd5:    dx1_sh_r[s] <= bus.cfg_data;
            3'd6:    en_sh_r[s]  <= bus.cfg_data[0];
            default: ;
          endcase
        end
      end
    end
  end

  // Next edge values, decided against the active set before any same-cycle commit.
  always_comb begin
    for (int s = 0; s < N_SLOTS; s++) begin
      x0_nx_s[s] = 14'd0;
      x1_nx_s[s] = 14'd0;
      if (!en_r[s]) begin
        x0_nx_s[s] = 14'd0;
        x1_nx_s[s] = 14'd0;
      end else if (bus.line_y == ys_r[s]) begin
        x0_nx_s[s] = x0i_r[s];
        x1_nx_s[s] = x1i_r[s];
      end else if ((bus.line_y > ys_r[s]) && (bus.line_y < ye_r[s])) begin
        x0_nx_s[s] = x0_r[s] + dx0_r[s];
        x1_nx_s[s] = x1_r[s] + dx1_r[s];
      end else begin
        x0_nx_s[s] = 14'd0;
        x1_nx_s[s] = 14'd0;
      end
    end
  end

  // Frame-end commit of shadow to active, and per-line edge stepping.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        ys_r[s]  <= 10'd0;
        ye_r[s]  <= 10'd0;
        x0i_r[s] <= 14'd0;
        x1i_r[s] <= 14'd0;
        dx0_r[s] <= 14'd0;
        dx1_r[s] <= 14'd0;
        en_r[s]  <= 1'b0;
        x0_r[s]  <= 14'd0;
        x1_r[s]  <= 14'd0;
      end
      frame_commit_r <= 1'b0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++) begin
        if (commit_s) begin
          ys_r[s]  <= ys_sh_r[s];
          ye_r[s]  <= ye_sh_r[s];
          x0i_r[s] <= x0i_sh_r[s];
          x1i_r[s] <= x1i_sh_r[s];
          dx0_r[s] <= dx0_sh_r[s];
          dx1_r[s] <= dx1_sh_r[s];
          en_r[s]  <= en_sh_r[s];
        end
        if (bus.line_end) begin
          x0_r[s] <= x0_nx_s[s];
          x1_r[s] <= x1_nx_s[s];
        end
      end
      frame_commit_r <= commit_s;
    end
  end

  // Coverage of the current pixel; later slots override earlier ones.
  always_comb begin
    hit_s  = 1'b0;
    slot_s = 3'd0;
    for (int s = 0; s < N_SLOTS; s++) begin
      if (en_r[s] && (x0_r[s][13:4] <= bus.pix_x) && (bus.pix_x < x1_r[s][13:4])) begin
        hit_s  = 1'b1;
        slot_s = 3'(s);
      end else begin
        hit_s  = hit_s;
        slot_s = slot_s;
      end
    end
  end

  // Registered coverage outputs.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hit_r      <= 1'b0;
      hit_slot_r <= 3'd0;
    end else begin
      hit_r      <= hit_s;
      hit_slot_r <= slot_s;
    end
  end

  assign bus.hit          = hit_r;
  assign bus.hit_slot     = hit_slot_r;
  assign bus.frame_commit = frame_commit_r;
endmodule
